fp32_to_posit32: RTL

- Sequential converter that reads IEEE-754 binary32 results from the fp32 adder and encodes them as posit<32,2> for the posit datapath.
- Takes the adder's `z` word and its 2-bit status code, with one valid/ready handshake on each side.
- Encodes the regime serially, one bit per cycle, then applies round-to-nearest-even and saturates to the posit range.

---
 rtl/posit_pkg.sv | 31 +++
 rtl/fp32_to_posit32_if.sv | 24 ++
 rtl/fp32_classify.sv | 46 ++++
 rtl/fp32_to_posit32.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// rtl/posit_pkg.sv - shared constants and types for the fp32 <-> posit<32,2> converters
package posit_pkg;

    localparam int NBITS     = 32;
    localparam int ES        = 2;
    localparam int FP32_BIAS = 127;
    localparam int SCALE_MAX = 120;
    localparam int SCALE_MIN = -120;

    localparam logic [NBITS-1:0] NAR    = 32'h8000_0000;
    localparam logic [NBITS-1:0] MAXPOS = 32'h7FFF_FFFF;
    localparam logic [NBITS-1:0] MINPOS = 32'h0000_0001;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        TERM,
        SHIFT,
        ROUND,
        DONE
    } conv_state_t;

    typedef enum logic [2:0] {
        CLS_NAR,
        CLS_ZERO,
        CLS_MIN,
        CLS_MAX,
        CLS_NORM
    } fp_class_t;

endpackage

// File: rtl/fp32_to_posit32_if.sv
// rtl/fp32_to_posit32_if.sv - operand/result handshake bundle for the fp32 -> posit converter
interface fp32_to_posit32_if;
    import posit_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      fp_in;
    logic [1:0]       fp_flag;
    logic             out_valid;
    logic             out_ready;
    logic [NBITS-1:0] posit_out;
    logic             out_nar;

    modport master (
        output in_valid, fp_in, fp_flag, out_ready,
        input  in_ready, out_valid, posit_out, out_nar
    );

    modport slave (
        input  in_valid, fp_in, fp_flag, out_ready,
        output in_ready, out_valid, posit_out, out_nar
    );

endinterface

// File: rtl/fp32_classify.sv
// rtl/fp32_classify.sv - classifies a binary32 word and derives posit regime/exponent fields
module fp32_classify
    import posit_pkg::*;
(
    input  logic [31:0]   fp_in,
    input  logic [1:0]    fp_flag,
    output fp_class_t     cls,
    output logic          sign,
    output logic [ES-1:0] e,
    output logic [4:0]    run,
    output logic          fill
);

    logic [7:0]         exp_f;
    logic [22:0]        frac;
    logic signed [8:0]  scale;
    logic signed [8:0]  k;
    logic signed [8:0]  neg_k;

    assign exp_f = fp_in[30:23];
    assign frac  = fp_in[22:0];
    assign sign  = fp_in[31];

    assign scale = $signed({1'b0, exp_f}) - 9'(FP32_BIAS);
    assign k     = scale >>> 2;
    assign neg_k = -k;
    assign e     = scale[ES-1:0];
    assign fill  = ~k[8];

    // run covers the regime fill bits only; the terminator is shifted separately
    assign run   = k[8] ? neg_k[4:0] : k[4:0] + 5'd1;

    always_comb begin
        cls = CLS_NORM;
        if (fp_flag == 2'b01 || fp_flag == 2'b11 || exp_f == 8'hFF) begin
            cls = CLS_NAR;
        end else if (exp_f == 8'h00 && frac == 23'd0) begin
            cls = CLS_ZERO;
        end else if (exp_f == 8'h00 || int'(scale) < SCALE_MIN) begin
            cls = CLS_MIN;
        end else if (int'(scale) > SCALE_MAX) begin
            cls = CLS_MAX;
        end
    end

endmodule

// File: rtl/fp32_to_posit32.sv
// rtl/fp32_to_posit32.sv - serial binary32 to posit<32,2> converter, one regime bit per cycle
module fp32_to_posit32
    import posit_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    fp32_to_posit32_if.slave    bus
);

    conv_state_t      state;
    conv_state_t      next_state;

    logic [31:0]      op_fp;
    logic [1:0]       op_flag;
    logic             sign_r;
    logic [63:0]      w;
    logic             fill;
    logic [4:0]       run_r;
    logic [4:0]       cnt;
    logic             out_valid_r;
    logic [NBITS-1:0] posit_r;
    logic             nar_r;

    fp_class_t        c_cls;
    logic             c_sign;
    logic [ES-1:0]    c_e;
    logic [4:0]       c_run;
    logic             c_fill;

    logic [30:0]      body;
    logic             guard;
    logic             sticky;
    logic [31:0]      mag;
    logic [31:0]      mag_c;
    logic [31:0]      rounded;

    fp32_classify u_classify (
        .fp_in   (op_fp),
        .fp_flag (op_flag),
        .cls     (c_cls),
        .sign    (c_sign),
        .e       (c_e),
        .run     (c_run),
        .fill    (c_fill)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.in_valid) next_state = UNPACK;
            UNPACK: begin
                case (c_cls)
                    CLS_NAR, CLS_ZERO: next_state = DONE;
                    CLS_MIN, CLS_MAX:  next_state = ROUND;
                    default:           next_state = TERM;
                endcase
            end
            TERM:    next_state = SHIFT;
            SHIFT:   if (cnt == run_r - 5'd1) next_state = ROUND;
            ROUND:   next_state = DONE;
            DONE:    if (out_valid_r && bus.out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = out_valid_r;
        bus.posit_out = posit_r;
        bus.out_nar   = nar_r;
    end

    // Round to nearest even on the 31-bit body, then keep the result off zero and NaR
    always_comb begin
        body    = w[63:33];
        guard   = w[32];
        sticky  = |w[31:0];
        mag     = {1'b0, body} + {31'd0, guard & (sticky | body[0])};
        mag_c   = mag;
        if (mag > MAXPOS) begin
            mag_c = MAXPOS;
        end else if (mag == 32'd0) begin
            mag_c = MINPOS;
        end
        rounded = sign_r ? (~mag_c + 32'd1) : mag_c;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_fp       <= '0;
            op_flag     <= '0;
            sign_r      <= 1'b0;
            w           <= '0;
            fill        <= 1'b0;
            run_r       <= '0;
            cnt         <= '0;
            out_valid_r <= 1'b0;
            posit_r     <= '0;
            nar_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_fp   <= bus.fp_in;
                        op_flag <= bus.fp_flag;
                    end
                end
                UNPACK: begin
                    sign_r <= c_sign;
                    cnt    <= '0;
                    nar_r  <= 1'b0;
                    case (c_cls)
                        CLS_NAR: begin
                            posit_r <= NAR;
                            nar_r   <= 1'b1;
                        end
                        CLS_ZERO: posit_r <= '0;
                        // Saturated magnitudes ride through ROUND with zero guard/sticky
                        CLS_MIN:  w <= {MINPOS[30:0], 33'd0};
                        CLS_MAX:  w <= {MAXPOS[30:0], 33'd0};
                        default: begin
                            w     <= {c_e, op_fp[22:0], 39'd0};
                            run_r <= c_run;
                            fill  <= c_fill;
                        end
                    endcase
                end
                TERM:  w <= {~fill, w[63:1]};
                SHIFT: begin
                    w   <= {fill, w[63:1]};
                    cnt <= cnt + 5'd1;
                end
                ROUND: posit_r <= rounded;
                DONE: begin
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
